// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side enqueue and decode-side dequeue signals of the IF/ID instruction queue.
// slave modport is the queue itself; master modport is the fetch/decode side driving it.
interface if_id_queue_if #(
  parameter int DEPTH = 4
) ();
  logic                       flush_i;
  logic                       enq_valid_i;
  logic [31:0]                enq_pc_i;
  logic [31:0]                enq_pc_plus4_i;
  logic [31:0]                enq_instr_i;
  logic                       enq_ready_o;
  logic                       deq_valid_o;
  logic [31:0]                deq_pc_o;
  logic [31:0]                deq_pc_plus4_o;
  logic [31:0]                deq_instr_o;
  logic                       deq_ready_i;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  modport slave (
    input  flush_i, enq_valid_i, enq_pc_i, enq_pc_plus4_i, enq_instr_i, deq_ready_i,
    output enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_plus4_o, deq_instr_o, count_o
  );
  modport master (
    output flush_i, enq_valid_i, enq_pc_i, enq_pc_plus4_i, enq_instr_i, deq_ready_i,
    input  enq_ready_o, deq_valid_o, deq_pc_o, deq_pc_plus4_o, deq_instr_o, count_o
  );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: first-word-fall-through instruction queue between fetch and decode.
// Ports: clk, rst_n (async active-low), q (if_id_queue_if.slave): enqueue tuple
// {pc, pc_plus4, instr} with valid/ready, dequeue head with valid/ready, flush, occupancy.
module if_id_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic         clk,
  input logic         rst_n,
  if_id_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [95:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          enq, deq;
  logic [95:0]   head;
  assign q.enq_ready_o    = count != CW'(DEPTH);
  assign q.deq_valid_o    = count != '0;
  assign q.count_o        = count;
  assign enq              = q.enq_valid_i && q.enq_ready_o && !q.flush_i;
  assign deq              = q.deq_valid_o && q.deq_ready_i && !q.flush_i;
  assign head             = mem[rd_ptr];
  assign q.deq_pc_o       = q.deq_valid_o ? head[95:64] : 32'h0;
  assign q.deq_pc_plus4_o = q.deq_valid_o ? head[63:32] : 32'h0;
  assign q.deq_instr_o    = q.deq_valid_o ? head[31:0]  : NOP_INSTR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(deq);
      wr_ptr <= wr_ptr + AW'(enq);
      count  <= count + CW'(enq) - CW'(deq);
    end
  always_ff @(posedge clk)
    if (enq) mem[wr_ptr] <= {q.enq_pc_i, q.enq_pc_plus4_i, q.enq_instr_i};
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed plus random stimulus, reference FIFO model and negedge monitor for if_id_queue.
module tb_if_id_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] instr;
  } entry_t;
  logic   clk = 0;
  logic   rst_n = 0;
  int     vectors = 0;
  int     miscompares = 0;
  entry_t model [$];
  if_id_queue_if #(.DEPTH(DEPTH)) bus ();
  if_id_queue #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (.clk(clk), .rst_n(rst_n), .q(bus));
  always #5 clk = ~clk;
  // Reference: an ordered list of accepted tuples; acceptance judged by its size only.
  always @(posedge clk or negedge rst_n)
    if (!rst_n || bus.flush_i) model.delete();
    else begin
      automatic bit d = model.size() > 0 && bus.deq_ready_i;
      automatic bit e = bus.enq_valid_i && model.size() < DEPTH;
      if (d) void'(model.pop_front());
      if (e) model.push_back({bus.enq_pc_i, bus.enq_pc_plus4_i, bus.enq_instr_i});
    end
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask
  // Monitor: compares the presented head and status against the model away from clock edges,
  // and 1ns after an asynchronous reset assertion to prove it acts without a clock.
  always begin
    @(negedge clk or negedge rst_n);
    #1;
    begin
      automatic entry_t h = model.size() > 0 ? model[0] : '{pc: 32'h0, p4: 32'h0, instr: NOP};
      chk("count",     32'(bus.count_o),     32'(model.size()));
      chk("deq_valid", 32'(bus.deq_valid_o), 32'(model.size() > 0));
      chk("enq_ready", 32'(bus.enq_ready_o), 32'(model.size() < DEPTH));
      chk("deq_pc",    bus.deq_pc_o,         h.pc);
      chk("deq_pc4",   bus.deq_pc_plus4_o,   h.p4);
      chk("deq_instr", bus.deq_instr_o,      h.instr);
    end
  end
  task automatic step(bit fl, bit ev, logic [31:0] pc, logic [31:0] instr, bit dr);
    bus.flush_i        = fl;
    bus.enq_valid_i    = ev;
    bus.enq_pc_i       = pc;
    bus.enq_pc_plus4_i = pc + 32'd4;
    bus.enq_instr_i    = instr;
    bus.deq_ready_i    = dr;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    rst_n = 1;
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'(i * 4), 32'hA000_0000 + 32'(i), 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    rst_n = 0;
    #3;
    step(0, 0, 0, 0, 0);
    rst_n = 1;
    step(0, 1, 32'h0, 32'hB000_0000, 0);
    for (int i = 1; i < 2 * DEPTH + 4; i++) step(0, 1, 32'(i * 4), 32'hB000_0000 + 32'(i), 1);
    repeat (3) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h20 + 32'(i * 4), 32'hC000_0000 + 32'(i), 0);
    step(1, 1, 32'h40, 32'hC000_0040, 1);
    step(0, 1, 32'h80, 32'hC000_0080, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 32'h100, 32'h0050_0093, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      bus.enq_pc_plus4_i = $urandom;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) == 0 ? 1'b1 : $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 300; i++) begin
      bus.flush_i        = $urandom_range(0, 29) == 0;
      bus.enq_valid_i    = $urandom_range(0, 1);
      bus.enq_pc_i       = $urandom;
      bus.enq_pc_plus4_i = $urandom;
      bus.enq_instr_i    = $urandom;
      bus.deq_ready_i    = $urandom_range(0, 1);
      @(posedge clk);
      #1;
    end
    step(0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
